// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} sched_state_t;

  localparam int DIV_MIN   = 2;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for clk_div_sched: wrap detect plus registered tick/div_clk decode.
// Optional mid-period pulse is built only when CLK_DIV_SCHED_PHASE_EN is defined.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_active,
  input  logic             i_active_next,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_div_next,
  output logic             o_wrap,
  output logic             o_tick,
  output logic             o_div_clk
`ifdef CLK_DIV_SCHED_PHASE_EN
  ,
  output logic             o_tick_half
`endif
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_highLen;

  // Outputs are decoded from the next count and next ratio so they line up with r_cnt.
  always_comb begin
    o_wrap    = i_active && (r_cnt == i_div - 1'b1);
    w_highLen = i_div_next - (i_div_next >> 1);
    if (!i_active_next || !i_active || o_wrap) begin
      w_cntNext = '0;
    end else begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      o_tick    <= 1'b0;
      o_div_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      o_tick    <= i_active_next && (w_cntNext == i_div_next - 1'b1);
      o_div_clk <= i_active_next && (w_cntNext < w_highLen);
    end
  end

`ifdef CLK_DIV_SCHED_PHASE_EN
  logic [CNT_W-1:0] w_halfIdx;

  assign w_halfIdx = (i_div_next >> 1) - 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tick_half <= 1'b0;
    end else begin
      o_tick_half <= i_active_next && (w_cntNext == w_halfIdx);
    end
  end
`endif

endmodule

// File: rtl/clk_div_sched.sv
// Programmable clock-enable scheduler: tick every N cycles plus a divided-clock level.
// Define CLK_DIV_SCHED_PHASE_EN to add the o_tick_half mid-period pulse.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_tick,
  output logic             o_div_clk,
  output logic             o_busy
`ifdef CLK_DIV_SCHED_PHASE_EN
  ,
  output logic             o_tick_half
`endif
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);

  sched_state_t     r_state;
  sched_state_t     w_stateNext;
  logic [CNT_W-1:0] r_divQ;
  logic [CNT_W-1:0] w_divNext;
  logic [CNT_W-1:0] r_pendQ;
  logic [CNT_W-1:0] w_pendNext;
  logic             w_accept;
  logic             w_cfgOk;
  logic             w_wrap;
  logic             w_active;
  logic             w_activeNext;

  // A ratio accepted mid-period is parked in r_pendQ so the old period never gets cut short.
  always_comb begin
    w_accept    = i_cfg_valid && o_cfg_ready;
    w_cfgOk     = w_accept && (i_cfg_div >= DIV_MIN_W);
    w_stateNext = r_state;
    w_divNext   = r_divQ;
    w_pendNext  = r_pendQ;
    case (r_state)
      IDLE: begin
        if (w_cfgOk) w_divNext = i_cfg_div;
        if (i_run) w_stateNext = RUN;
      end
      RUN: begin
        if (w_wrap) begin
          if (w_cfgOk) w_divNext = i_cfg_div;
          w_stateNext = i_run ? RUN : IDLE;
        end else if (w_cfgOk) begin
          w_pendNext  = i_cfg_div;
          w_stateNext = PEND;
        end else if (!i_run) begin
          w_stateNext = STOP;
        end
      end
      PEND: begin
        if (w_wrap) begin
          w_divNext   = r_pendQ;
          w_stateNext = i_run ? RUN : IDLE;
        end
      end
      STOP: begin
        if (w_wrap) begin
          w_stateNext = i_run ? RUN : IDLE;
        end else if (i_run) begin
          w_stateNext = RUN;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    w_active     = (r_state != IDLE);
    w_activeNext = (w_stateNext != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_divQ      <= DIV_RST;
      r_pendQ     <= '0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_divQ      <= w_divNext;
      r_pendQ     <= w_pendNext;
      o_busy      <= w_activeNext;
      o_cfg_err   <= w_accept && (i_cfg_div < DIV_MIN_W);
      o_cfg_ready <= (w_stateNext == IDLE) || (w_stateNext == RUN);
    end
  end

  clk_div_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_active     (w_active),
    .i_active_next(w_activeNext),
    .i_div        (r_divQ),
    .i_div_next   (w_divNext),
    .o_wrap       (w_wrap),
    .o_tick       (o_tick),
    .o_div_clk    (o_div_clk)
`ifdef CLK_DIV_SCHED_PHASE_EN
    ,
    .o_tick_half  (o_tick_half)
`endif
  );

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus randomized traffic
// compared against a period-level reference model.
module tb_clk_div_sched;

  logic       clk;
  logic       rst;
  logic       run;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       tick;
  logic       div_clk;
  logic       busy;

  int total;
  int bad;

  // Reference model: one period at a time, with its length, position and any queued ratio.
  bit mActive;
  int mPos;
  int mN;
  int mQueued;
  bit mDraining;
  bit mErr;

  clk_div_sched #(
    .CNT_W      (8),
    .DEFAULT_DIV(2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (run),
    .i_cfg_valid(cfg_valid),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_tick     (tick),
    .o_div_clk  (div_clk),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    mActive   = 1'b0;
    mPos      = 0;
    mN        = 2;
    mQueued   = 0;
    mDraining = 1'b0;
    mErr      = 1'b0;
  endfunction

  function automatic bit modelReady();
    return !mActive || (mQueued == 0 && !mDraining);
  endfunction

  function automatic void modelStep();
    bit acc;
    bit ok;
    int cd;
    cd   = int'(cfg_div);
    acc  = (cfg_valid === 1'b1) && modelReady();
    ok   = acc && (cd >= 2);
    mErr = acc && (cd < 2);
    if (!mActive) begin
      if (ok) mN = cd;
      if (run === 1'b1) begin
        mActive   = 1'b1;
        mPos      = 0;
        mDraining = 1'b0;
      end
    end else if (mPos == mN - 1) begin
      if (mQueued != 0) begin
        mN      = mQueued;
        mQueued = 0;
      end else if (ok) begin
        mN = cd;
      end
      mPos      = 0;
      mActive   = (run === 1'b1);
      mDraining = 1'b0;
    end else begin
      mPos = mPos + 1;
      if (ok) mQueued = cd;
      else if (mQueued == 0) mDraining = (run !== 1'b1);
    end
  endfunction

  function automatic logic [4:0] modelOut();
    logic t;
    logic d;
    t = mActive && (mPos == mN - 1);
    d = mActive && (mPos < (mN + 1) / 2);
    return {t, d, mActive, mErr, modelReady()};
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) modelReset();
    else modelStep();
  end

  task automatic primeRatio(input int n);
    rst       = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = 8'(n);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst       = 1'b1;
    run       = 1'b1;
    cfg_valid = 1'b1;
    cfg_div   = 8'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (obs !== 5'b00001 || obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL reset_hold%0d: got %b expected 00001", k, obs);
      end
    end
    cfg_valid = 1'b0;
    run       = 1'b0;
  endtask

  task automatic test_default_div();
    logic [4:0] obs;
    bit expTick;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs     = {tick, div_clk, busy, cfg_err, cfg_ready};
      expTick = (k % 2 == 0);
      total++;
      if (tick !== expTick || div_clk !== !expTick || obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL div2_cyc%0d: got %b expected tick=%b div_clk=%b model=%b",
                 k, obs, expTick, !expTick, modelOut());
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [4:0] obs;
    int tickAt[$];
    int expTicks[5];
    int hiCnt;
    expTicks = '{1, 7, 13, 19, 25};
    hiCnt    = 0;
    primeRatio(4);
    run = 1'b1;
    repeat (2) begin
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL chg_lead: got %b expected %b", obs, modelOut());
      end
    end
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL chg_ready_drop: got %b expected 0", cfg_ready);
    end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL chg_cyc%0d: got %b expected %b", i, obs, modelOut());
      end
      if (tick === 1'b1) tickAt.push_back(i);
      if (i >= 2 && i <= 7 && div_clk === 1'b1) hiCnt++;
      if (i == 2) begin
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL chg_ready_back: got %b expected 1", cfg_ready);
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= tickAt.size() || tickAt[j] != expTicks[j]) begin
        bad++;
        $display("[TB] FAIL chg_tick%0d: got cycle %0d expected cycle %0d",
                 j, (j < tickAt.size()) ? tickAt[j] : -1, expTicks[j]);
      end
    end
    total++;
    if (hiCnt != 3) begin
      bad++;
      $display("[TB] FAIL chg_div_clk_high: got %0d expected 3", hiCnt);
    end
  endtask

  task automatic test_cfg_err();
    logic [4:0] obs;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'($urandom_range(0, 1));
    @(negedge clk);
    cfg_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL err_pulse: got err=%b busy=%b ready=%b expected 1 1 1",
               cfg_err, busy, cfg_ready);
    end
    @(negedge clk);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_clear: got %b expected 0", cfg_err);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL err_after%0d: got %b expected %b", k, obs, modelOut());
      end
    end
  endtask

  task automatic test_stop();
    logic [4:0] obs;
    bit expTick[6];
    bit expDiv[6];
    bit expBusy[6];
    expTick = '{0, 0, 0, 0, 1, 0};
    expDiv  = '{1, 1, 1, 0, 0, 0};
    expBusy = '{1, 1, 1, 1, 1, 0};
    primeRatio(5);
    run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (tick !== expTick[k] || div_clk !== expDiv[k] || busy !== expBusy[k] ||
          obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL stop_cyc%0d: got %b expected tick=%b div_clk=%b busy=%b",
                 k, obs, expTick[k], expDiv[k], expBusy[k]);
      end
      if (k == 2) run = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    primeRatio(8);
    run = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs = {tick, div_clk, busy, cfg_err, cfg_ready};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("[TB] FAIL rstmid_state: got %b expected 00001", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tick !== 1'b0 || div_clk !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstmid_first: got tick=%b div_clk=%b expected 0 1", tick, div_clk);
    end
    @(negedge clk);
    total++;
    if (tick !== 1'b1 || div_clk !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_default_div: got tick=%b div_clk=%b expected 1 0",
               tick, div_clk);
    end
  endtask

  task automatic test_wrap_cfg();
    logic [4:0] obs;
    primeRatio(3);
    run = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (cfg_ready !== 1'b1 || tick !== (i == 7 || i == 14) || obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL wrapcfg_cyc%0d: got %b expected ready=1 tick=%b",
                 i, obs, (i == 7 || i == 14));
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      run       = ($urandom_range(0, 9) < 8);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = 8'($urandom_range(0, 10));
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      obs = {tick, div_clk, busy, cfg_err, cfg_ready};
      total++;
      if (obs !== modelOut()) begin
        bad++;
        $display("[TB] FAIL rand_cyc%0d: got %b expected %b", i, obs, modelOut());
      end
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    modelReset();
    test_reset();
    test_default_div();
    test_ratio_change();
    test_cfg_err();
    test_stop();
    test_reset_mid();
    test_wrap_cfg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
